// File: rtl/rv32_pkg.sv
// RV32I decode constants shared by the issue stage: opcode values, instruction
// field positions and the per-opcode operand/destination usage table.
package rv32_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  typedef struct packed {
    logic use_rs1;
    logic use_rs2;
    logic rd_we;
  } src_use_t;

  function automatic src_use_t decode_use(input logic [6:0] opc);
    src_use_t u;
    case (opc)
      OPC_OP:                      u = '{use_rs1: 1'b1, use_rs2: 1'b1, rd_we: 1'b1};
      OPC_OP_IMM, OPC_LOAD,
      OPC_JALR:                    u = '{use_rs1: 1'b1, use_rs2: 1'b0, rd_we: 1'b1};
      OPC_STORE, OPC_BRANCH:       u = '{use_rs1: 1'b1, use_rs2: 1'b1, rd_we: 1'b0};
      OPC_LUI, OPC_AUIPC, OPC_JAL: u = '{use_rs1: 1'b0, use_rs2: 1'b0, rd_we: 1'b1};
      default:                     u = '{use_rs1: 1'b0, use_rs2: 1'b0, rd_we: 1'b0};
    endcase
    return u;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, x0 never busy.
// A set on the same edge as a clear of the same bit wins (new write still in flight).
module reg_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_en,
  input  logic [4:0]  set_idx,
  input  logic        clr_en,
  input  logic [4:0]  clr_idx,
  input  logic        flush_clr_en,
  input  logic [4:0]  flush_clr_idx,
  input  logic [4:0]  rs1_idx,
  input  logic [4:0]  rs2_idx,
  input  logic [4:0]  rd_idx,
  output logic [31:0] busy,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        rd_busy
);

  logic [31:0] busy_r;
  logic [31:0] set_mask_s;
  logic [31:0] clr_mask_s;
  logic [31:0] fclr_mask_s;
  logic [31:0] busy_nxt_s;

  assign set_mask_s  = set_en       ? (32'd1 << set_idx)       : 32'd0;
  assign clr_mask_s  = clr_en       ? (32'd1 << clr_idx)       : 32'd0;
  assign fclr_mask_s = flush_clr_en ? (32'd1 << flush_clr_idx) : 32'd0;
  assign busy_nxt_s  = ((busy_r & ~clr_mask_s & ~fclr_mask_s) | set_mask_s) & ~32'd1;

  // Busy vector state
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 32'd0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy     = busy_r;
  assign rs1_busy = busy_r[rs1_idx];
  assign rs2_busy = busy_r[rs2_idx];
  assign rd_busy  = busy_r[rd_idx];

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: reads the register file for the offered instruction, stalls on
// RAW/WAW hazards against in-flight writes and registers operands for execute.
module id_issue_stage
  import rv32_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         if_valid,
  input  logic [31:0]  if_instr,
  input  logic [N-1:0] if_pc,
  output logic         if_ready,
  output logic [4:0]   br_a1,
  output logic [4:0]   br_a2,
  input  logic [N-1:0] br_rd1,
  input  logic [N-1:0] br_rd2,
  input  logic         wb_valid,
  input  logic [4:0]   wb_rd,
  input  logic [N-1:0] wb_data,
  input  logic         flush,
  output logic         ex_valid,
  input  logic         ex_ready,
  output logic [N-1:0] ex_pc,
  output logic [31:0]  ex_instr,
  output logic [N-1:0] ex_rs1_val,
  output logic [N-1:0] ex_rs2_val,
  output logic [4:0]   ex_rd,
  output logic         ex_rd_we,
  output logic [31:0]  sb_busy
);

  src_use_t     use_s;
  logic [4:0]   rs1_s, rs2_s, rd_s;
  logic         rd_we_s;
  logic         rs1_busy_s, rs2_busy_s, rd_busy_s;
  logic         wb_hit1_s, wb_hit2_s, wb_hitd_s;
  logic         rs1_ok_s, rs2_ok_s, waw_s, hazard_s;
  logic         if_ready_s, fire_s;
  logic [N-1:0] op1_s, op2_s;

  logic         ex_valid_r;
  logic [N-1:0] ex_pc_r;
  logic [31:0]  ex_instr_r;
  logic [N-1:0] ex_rs1_val_r, ex_rs2_val_r;
  logic [4:0]   ex_rd_r;
  logic         ex_rd_we_r;

  assign rs1_s   = if_instr[RS1_LSB +: 5];
  assign rs2_s   = if_instr[RS2_LSB +: 5];
  assign rd_s    = if_instr[RD_LSB +: 5];
  assign use_s   = decode_use(if_instr[OPC_LSB +: 7]);
  assign rd_we_s = use_s.rd_we && (rd_s != 5'd0);

  assign wb_hit1_s = wb_valid && (wb_rd == rs1_s);
  assign wb_hit2_s = wb_valid && (wb_rd == rs2_s);
  assign wb_hitd_s = wb_valid && (wb_rd == rd_s);

  // A writeback arriving this cycle satisfies a pending source or destination
  assign rs1_ok_s   = !use_s.use_rs1 || !rs1_busy_s || wb_hit1_s;
  assign rs2_ok_s   = !use_s.use_rs2 || !rs2_busy_s || wb_hit2_s;
  assign waw_s      = rd_we_s && rd_busy_s && !wb_hitd_s;
  assign hazard_s   = !rs1_ok_s || !rs2_ok_s || waw_s;
  assign if_ready_s = !flush && !hazard_s && (!ex_valid_r || ex_ready);
  assign fire_s     = if_valid && if_ready_s;

  // Register file returns the old value during a same-cycle write, so bypass it
  assign op1_s = (use_s.use_rs1 && wb_hit1_s && (rs1_s != 5'd0)) ? wb_data : br_rd1;
  assign op2_s = (use_s.use_rs2 && wb_hit2_s && (rs2_s != 5'd0)) ? wb_data : br_rd2;

  reg_scoreboard u_sb (
    .clk           (clk),
    .rst           (rst),
    .set_en        (fire_s && rd_we_s),
    .set_idx       (rd_s),
    .clr_en        (wb_valid),
    .clr_idx       (wb_rd),
    .flush_clr_en  (flush && ex_valid_r && ex_rd_we_r),
    .flush_clr_idx (ex_rd_r),
    .rs1_idx       (rs1_s),
    .rs2_idx       (rs2_s),
    .rd_idx        (rd_s),
    .busy          (sb_busy),
    .rs1_busy      (rs1_busy_s),
    .rs2_busy      (rs2_busy_s),
    .rd_busy       (rd_busy_s)
  );

  // Execute-facing output register
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_r   <= 1'b0;
      ex_pc_r      <= {N{1'b0}};
      ex_instr_r   <= 32'd0;
      ex_rs1_val_r <= {N{1'b0}};
      ex_rs2_val_r <= {N{1'b0}};
      ex_rd_r      <= 5'd0;
      ex_rd_we_r   <= 1'b0;
    end else if (flush) begin
      ex_valid_r <= 1'b0;
    end else if (fire_s) begin
      ex_valid_r   <= 1'b1;
      ex_pc_r      <= if_pc;
      ex_instr_r   <= if_instr;
      ex_rs1_val_r <= op1_s;
      ex_rs2_val_r <= op2_s;
      ex_rd_r      <= rd_s;
      ex_rd_we_r   <= rd_we_s;
    end else if (ex_ready) begin
      ex_valid_r <= 1'b0;
    end else begin
      ex_valid_r <= ex_valid_r;
    end
  end

  assign br_a1      = rs1_s;
  assign br_a2      = rs2_s;
  assign if_ready   = if_ready_s;
  assign ex_valid   = ex_valid_r;
  assign ex_pc      = ex_pc_r;
  assign ex_instr   = ex_instr_r;
  assign ex_rs1_val = ex_rs1_val_r;
  assign ex_rs2_val = ex_rs2_val_r;
  assign ex_rd      = ex_rd_r;
  assign ex_rd_we   = ex_rd_we_r;

endmodule

// File: tb/tb_id_issue_stage.sv
// Scenario-driven bench for id_issue_stage with a register-file model and an
// expected-output queue that is checked whenever execute takes or drops an entry.
module tb_id_issue_stage;

  localparam int N = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, if_valid, if_ready, wb_valid, flush, ex_valid, ex_ready, ex_rd_we;
  logic [31:0]  if_instr, ex_instr, sb_busy;
  logic [N-1:0] if_pc, br_rd1, br_rd2, wb_data, ex_pc, ex_rs1_val, ex_rs2_val;
  logic [4:0]   br_a1, br_a2, wb_rd, ex_rd;

  logic [31:0] rf [32];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        rd_we;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  id_issue_stage #(.N(N)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .br_a1(br_a1), .br_a2(br_a2), .br_rd1(br_rd1), .br_rd2(br_rd2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_instr(ex_instr),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
    .sb_busy(sb_busy)
  );

  // Register file model: async read, write on wb strobe, x0 hard-wired to zero
  assign br_rd1 = rf[br_a1];
  assign br_rd2 = rf[br_a2];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'd0 : 32'h100 + 32'(i);
    end else if (wb_valid && wb_rd != 5'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  // {uses rs1, uses rs2, writes rd}
  function automatic logic [2:0] tb_use(input logic [6:0] opc);
    case (opc)
      7'b0110011:                         return 3'b111;
      7'b0010011, 7'b0000011, 7'b1100111: return 3'b101;
      7'b0100011, 7'b1100011:             return 3'b110;
      7'b0110111, 7'b0010111, 7'b1101111: return 3'b001;
      default:                            return 3'b000;
    endcase
  endfunction

  task automatic push_exp();
    exp_t e;
    logic [2:0] u;
    logic [4:0] a1, a2;
    u  = tb_use(if_instr[6:0]);
    a1 = if_instr[19:15];
    a2 = if_instr[24:20];
    e.pc    = if_pc;
    e.instr = if_instr;
    e.rs1   = (u[2] && wb_valid && wb_rd == a1 && a1 != 5'd0) ? wb_data : rf[a1];
    e.rs2   = (u[1] && wb_valid && wb_rd == a2 && a2 != 5'd0) ? wb_data : rf[a2];
    e.rd    = if_instr[11:7];
    e.rd_we = u[0] && (if_instr[11:7] != 5'd0);
    exp_q.push_back(e);
  endtask

  // Pop and compare whenever execute takes the entry or it is flushed away
  always @(negedge clk) begin
    if (!rst && ex_valid && (ex_ready || flush)) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: ex_pc=%h ex_instr=%h but no output expected", ex_pc, ex_instr);
      end else begin
        e = exp_q.pop_front();
        if (ex_pc !== e.pc || ex_instr !== e.instr || ex_rs1_val !== e.rs1 ||
            ex_rs2_val !== e.rs2 || ex_rd !== e.rd || ex_rd_we !== e.rd_we) begin
          errors++;
          $display("FAIL sb_ex: got pc=%h instr=%h rs1=%h rs2=%h rd=%0d we=%b, expected pc=%h instr=%h rs1=%h rs2=%h rd=%0d we=%b",
                   ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_rd, ex_rd_we,
                   e.pc, e.instr, e.rs1, e.rs2, e.rd, e.rd_we);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0; wb_valid = 1'b0;
    wb_rd = 5'd0; wb_data = 32'd0; flush = 1'b0; ex_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb_busy !== 32'd0 || ex_valid !== 1'b0 || ex_pc !== 32'd0 || ex_instr !== 32'd0 ||
        ex_rd !== 5'd0 || ex_rd_we !== 1'b0 || ex_rs1_val !== 32'd0 || ex_rs2_val !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%h valid=%b pc=%h instr=%h rd=%0d we=%b, expected all zero",
               sb_busy, ex_valid, ex_pc, ex_instr, ex_rd, ex_rd_we);
    end
    rst = 1'b0;
    if_instr = enc_addi(5'd1, 5'd0, 12'd1);
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready: got %b expected 1", if_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    ex_ready = 1'b1; if_valid = 1'b1;
    if_instr = enc_addi(5'd5, 5'd0, 12'd1); if_pc = 32'h100;
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %b expected 1", if_ready); end
    push_exp();
    @(posedge clk); #1;
    checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd5) begin errors++; $display("FAIL b2b_rd5: got valid=%b rd=%0d expected 1/5", ex_valid, ex_rd); end
    if_instr = enc_addi(5'd6, 5'd0, 12'd2); if_pc = 32'h104;
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %b expected 1", if_ready); end
    push_exp();
    @(posedge clk); #1;
    checks++;
    if (ex_rd !== 5'd6 || sb_busy !== 32'h60) begin errors++; $display("FAIL b2b_rd6: got rd=%0d busy=%h expected 6/00000060", ex_rd, sb_busy); end
    if_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ex_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got valid=%b expected 0", ex_valid); end
  endtask

  task automatic test_raw();
    if_valid = 1'b1; if_instr = enc_add(5'd7, 5'd5, 5'd6); if_pc = 32'h108;
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b0) begin errors++; $display("FAIL raw_stall0: got %b expected 0", if_ready); end
    @(posedge clk); #1;
    wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h22;
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b0) begin errors++; $display("FAIL raw_stall1: got %b expected 0", if_ready); end
    @(posedge clk); #1;
    wb_rd = 5'd5; wb_data = 32'h11;
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b1) begin errors++; $display("FAIL raw_release: got %b expected 1", if_ready); end
    push_exp();
    @(posedge clk); #1;
    wb_valid = 1'b0; if_valid = 1'b0;
    checks++;
    if (ex_rs1_val !== 32'h11 || ex_rs2_val !== 32'h22 || sb_busy !== 32'h80) begin
      errors++;
      $display("FAIL raw_bypass: got rs1=%h rs2=%h busy=%h expected 11/22/00000080", ex_rs1_val, ex_rs2_val, sb_busy);
    end
  endtask

  task automatic test_waw();
    if_valid = 1'b1; if_instr = enc_addi(5'd8, 5'd0, 12'd3); if_pc = 32'h10c;
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b1) begin errors++; $display("FAIL waw_first: got %b expected 1", if_ready); end
    push_exp();
    @(posedge clk); #1;
    checks++;
    if (sb_busy !== 32'h180) begin errors++; $display("FAIL waw_busy0: got %h expected 00000180", sb_busy); end
    if_instr = enc_addi(5'd8, 5'd0, 12'd4); if_pc = 32'h110;
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b0) begin errors++; $display("FAIL waw_stall: got %b expected 0", if_ready); end
    @(posedge clk); #1;
    wb_valid = 1'b1; wb_rd = 5'd8; wb_data = 32'd3;
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b1) begin errors++; $display("FAIL waw_release: got %b expected 1", if_ready); end
    push_exp();
    @(posedge clk); #1;
    checks++;
    if (sb_busy !== 32'h180 || ex_pc !== 32'h110) begin errors++; $display("FAIL waw_set_wins: got busy=%h pc=%h expected 00000180/110", sb_busy, ex_pc); end
    if_valid = 1'b0; wb_rd = 5'd7; wb_data = 32'h77;
    @(posedge clk); #1;
    wb_rd = 5'd8; wb_data = 32'd4;
    @(posedge clk); #1;
    wb_valid = 1'b0;
    checks++;
    if (sb_busy !== 32'd0) begin errors++; $display("FAIL waw_retire: got %h expected 00000000", sb_busy); end
  endtask

  task automatic test_backpressure();
    ex_ready = 1'b1; if_valid = 1'b1; if_instr = enc_addi(5'd10, 5'd0, 12'd7); if_pc = 32'h200;
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b1) begin errors++; $display("FAIL bp_load: got %b expected 1", if_ready); end
    push_exp();
    @(posedge clk); #1;
    ex_ready = 1'b0; if_instr = enc_addi(5'd11, 5'd0, 12'd8); if_pc = 32'h204;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (if_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_c%0d: got %b expected 0", c, if_ready); end
      @(posedge clk); #1;
      checks++;
      if (ex_valid !== 1'b1 || ex_pc !== 32'h200 || ex_rd !== 5'd10 ||
          ex_instr !== enc_addi(5'd10, 5'd0, 12'd7)) begin
        errors++;
        $display("FAIL bp_hold_c%0d: got valid=%b pc=%h rd=%0d expected 1/200/10", c, ex_valid, ex_pc, ex_rd);
      end
    end
    ex_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b expected 1", if_ready); end
    push_exp();
    @(posedge clk); #1;
    checks++;
    if (ex_pc !== 32'h204 || sb_busy !== 32'hC00) begin errors++; $display("FAIL bp_next: got pc=%h busy=%h expected 204/00000C00", ex_pc, sb_busy); end
    if_valid = 1'b0;
  endtask

  task automatic test_flush();
    if_valid = 1'b1; if_instr = enc_addi(5'd9, 5'd0, 12'd9); if_pc = 32'h300;
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b1) begin errors++; $display("FAIL flush_load: got %b expected 1", if_ready); end
    push_exp();
    @(posedge clk); #1;
    ex_ready = 1'b0; if_valid = 1'b0;
    checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd9 || sb_busy !== 32'hE00) begin
      errors++;
      $display("FAIL flush_pre: got valid=%b rd=%0d busy=%h expected 1/9/00000E00", ex_valid, ex_rd, sb_busy);
    end
    flush = 1'b1; if_valid = 1'b1; if_instr = enc_addi(5'd12, 5'd0, 12'd1); if_pc = 32'h304;
    wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'h1010;
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b0) begin errors++; $display("FAIL flush_no_fire: got %b expected 0", if_ready); end
    @(posedge clk); #1;
    flush = 1'b0; if_valid = 1'b0; wb_rd = 5'd11;
    checks++;
    if (ex_valid !== 1'b0 || sb_busy !== 32'h800) begin
      errors++;
      $display("FAIL flush_post: got valid=%b busy=%h expected 0/00000800", ex_valid, sb_busy);
    end
    @(posedge clk); #1;
    wb_valid = 1'b0; ex_ready = 1'b1;
    checks++;
    if (sb_busy !== 32'd0) begin errors++; $display("FAIL flush_retire: got %h expected 00000000", sb_busy); end
  endtask

  task automatic test_reset_mid_stall();
    ex_ready = 1'b1; if_valid = 1'b1; if_instr = enc_addi(5'd5, 5'd0, 12'd1); if_pc = 32'h400;
    @(negedge clk);
    push_exp();
    @(posedge clk); #1;
    ex_ready = 1'b0; if_instr = enc_add(5'd7, 5'd5, 5'd0); if_pc = 32'h404;
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", if_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sb_busy !== 32'd0 || ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got busy=%h valid=%b expected 00000000/0", sb_busy, ex_valid);
    end
    exp_q.delete();
    rst = 1'b0; ex_ready = 1'b1; if_instr = enc_addi(5'd0, 5'd0, 12'd5); if_pc = 32'h500;
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b expected 1", if_ready); end
    push_exp();
    @(posedge clk); #1;
    if_valid = 1'b0;
    checks++;
    if (ex_valid !== 1'b1 || ex_rd_we !== 1'b0 || sb_busy !== 32'd0) begin
      errors++;
      $display("FAIL x0_write: got valid=%b we=%b busy=%h expected 1/0/00000000", ex_valid, ex_rd_we, sb_busy);
    end
  endtask

  task automatic test_drain();
    ex_ready = 1'b1; if_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drain: %0d outputs never appeared, expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_raw();
    test_waw();
    test_backpressure();
    test_flush();
    test_reset_mid_stall();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_issue_stage.md
Name: id_issue_stage

Overview:
- Decode/issue stage directly upstream of the register file: takes fetched RV32I instructions and drives the register-file read addresses.
- Captures the read data, with a same-cycle writeback bypass, into an output register for execute.
- A 32-bit scoreboard stalls issue on RAW/WAW hazards against in-flight writes until their writeback arrives.

Parameters:
- N, 32, data/PC width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- if_valid  in  1  fetch offers an instruction
- if_instr  in  32  instruction word
- if_pc  in  N  instruction PC
- if_ready  out  1  stage accepts this cycle
- br_a1, br_a2  out  5  register-file read addresses (combinational rs1/rs2 of if_instr)
- br_rd1, br_rd2  in  N  register-file asynchronous read data
- wb_valid  in  1  writeback this cycle (same strobe as register-file we)
- wb_rd  in  5  writeback register
- wb_data  in  N  writeback data
- flush  in  1  discard the instruction held in the output register
- ex_valid  out  1  output register holds an instruction
- ex_ready  in  1  execute consumes
- ex_pc  out  N  registered PC
- ex_instr  out  32  registered instruction
- ex_rs1_val, ex_rs2_val  out  N  registered operands
- ex_rd  out  5  destination register
- ex_rd_we  out  1  instruction writes rd
- sb_busy  out  32  scoreboard vector (debug)

Behaviour:
- Fields: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7], opcode=instr[6:0].
- Use table by opcode:
  - OP 0110011: rs1, rs2, writes rd.
  - OP-IMM 0010011, LOAD 0000011, JALR 1100111: rs1, writes rd.
  - STORE 0100011, BRANCH 1100011: rs1, rs2, no write.
  - LUI 0110111, AUIPC 0010111, JAL 1101111: no sources, writes rd.
  - Any other opcode: no sources, no write.
- Register x0 is never busy, and rd_we is forced to 0 when rd=0.
- Source-ready rule, per used source rs: ready if !busy[rs], or if (wb_valid && wb_rd==rs).
- hazard = a used source is not ready, OR (rd_we && busy[rd] && !(wb_valid && wb_rd==rd)).
- if_ready = !flush && !hazard && (!ex_valid || ex_ready). if_ready depends combinationally on if_instr, which is permitted.
- Fire = if_valid && if_ready. On fire, the output register loads pc, instr, rd and rd_we next edge, and ex_valid=1.
- Operand mux (the register file returns the old value on same-cycle write):
  - if wb_valid && wb_rd==rs && rs!=0, operand = wb_data; else br_rdX.
  - Unused sources register br_rdX unchanged.
- No fire && ex_ready: ex_valid clears. No fire && !ex_ready: output register holds all fields stable.
- Scoreboard edge update, per bit:
  - Clear when wb_valid && wb_rd==i.
  - Set on fire when rd_we && rd==i. Set wins over a same-cycle clear of the same bit.
  - On flush with ex_valid && ex_rd_we, clear busy[ex_rd] (that write will never retire).
- Flush:
  - ex_valid=0 next edge; no fire in the flush cycle.
  - Execute must not treat ex_valid && ex_ready as a transfer in a flush cycle.
  - A concurrent wb_valid still clears its bit.
- Writeback to a non-busy register is legal and leaves busy unchanged.
- Reset (sync, priority over everything): sb_busy=0, ex_valid=0, ex_pc=0, ex_instr=0 (then ex_rs1_val=ex_rs2_val=0, ex_rd=0, ex_rd_we=0). if_ready follows the formula from the first post-reset cycle.
- Latency: accepted instruction appears at ex_* the next cycle. Throughput is 1/cycle with no hazards.

Decomposition:
- Shared package rv32_pkg: opcode constants (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC) and field bit positions.
- Sub-module reg_scoreboard:
  - 32-bit busy vector with set (en, idx), clear (en, idx) and flush-clear ports.
  - Set-over-clear priority and x0 masking.
  - Combinational busy lookups for rs1, rs2 and rd.

Test Plan:
- Back-to-back independent: addi x5,x0,1 then addi x6,x0,2 with ex_ready=1 -> if_ready=1 both cycles; ex_rd=5 then 6; sb_busy bits 5 and 6 set.
- RAW stall: add x7,x5,x6 while busy[5] -> if_ready=0 until wb_valid, wb_rd=5, wb_data=0x11. In that cycle fire occurs and ex_rs1_val=0x11 (bypass), not the stale br_rd1.
- WAW: second write to x8 while busy[8] -> stalled. wb to x8 and issue in the same cycle -> busy[8] remains 1.
- Backpressure: ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* fields stable, if_ready=0. Release -> next instruction loads on the following edge.
- Flush: ex holds addi x9 (busy[9]=1), flush=1 -> ex_valid=0 next cycle, busy[9]=0, no fire that cycle.
- Reset mid-stall: rst=1 with busy[5]=1 and ex_valid=1 -> sb_busy=0 and ex_valid=0 after the edge. x0 check: addi x0,x0,5 -> ex_rd_we=0 and busy stays 0.
